// File: rtl/ts_write_sched.sv
// TurboSound write scheduler: queues CPU port writes, replays them to one of two
// YM2203 chips on CE_CPU ticks with enforced spacing, and decodes F8h-FFh control bytes.
module ts_write_sched #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned GAP   = 3
) (
  input  logic       CLK,
  input  logic       RESET_N,
  input  logic       CE_CPU,
  input  logic       WR,
  input  logic       A0,
  input  logic [7:0] DI,
  output logic [7:0] DO,
  output logic       YM_A0,
  output logic [7:0] YM_DI,
  output logic [1:0] YM_WE,
  input  logic [7:0] DO0,
  input  logic [7:0] DO1,
  output logic       FM_ENA,
  output logic       BUSY,
  output logic       OVF
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned GW = (GAP > 0) ? $clog2(GAP + 1) : 1;
  localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_GAP
  } state_t;

  state_t        state_q, state_d;
  logic [GW-1:0] gap_q, gap_d;

  logic [8:0]    mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;

  logic          sel_q, sel_d;
  logic          stat_q, stat_d;
  logic          fm_q, fm_d;
  logic          ovf_q, ovf_d;
  logic          ym_a0_q, ym_a0_d;
  logic [7:0]    ym_di_q, ym_di_d;
  logic [1:0]    ym_we_q, ym_we_d;

  logic [8:0]    head;
  logic          head_cmd;
  logic          full;
  logic          pop;
  logic          push;
  logic          busy;

  assign head     = mem_q[rd_ptr_q];
  assign head_cmd = ~head[8] && (head[7:3] == 5'b11111);
  assign full     = (count_q == FULL_CNT);
  assign pop      = (state_q == S_IDLE) && CE_CPU && (count_q != '0) && (gap_q == '0);
  // A full FIFO still takes the write when the head leaves in the same CLK.
  assign push     = WR && (!full || pop);
  assign busy     = (count_q != '0) || (gap_q != '0);

  always_comb begin
    state_d  = state_q;
    gap_d    = gap_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    sel_d    = sel_q;
    stat_d   = stat_q;
    fm_d     = fm_q;
    ovf_d    = ovf_q;
    ym_a0_d  = ym_a0_q;
    ym_di_d  = ym_di_q;
    ym_we_d  = '0;

    if (push) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
    case ({push, pop})
      2'b10:   count_d = count_q + (AW + 1)'(1);
      2'b01:   count_d = count_q - (AW + 1)'(1);
      default: count_d = count_q;
    endcase

    if (WR && full && !pop) begin
      ovf_d = 1'b1;
    end

    // The gap counter is armed at the issue edge so BUSY stays high through ISSUE.
    case (state_q)
      S_IDLE: begin
        if (pop) begin
          state_d = S_ISSUE;
          if (head_cmd) begin
            sel_d  = ~head[0];
            stat_d = ~head[1];
            fm_d   = ~head[2];
          end else begin
            ym_a0_d = head[8];
            ym_di_d = head[7:0];
            ym_we_d = sel_q ? 2'b10 : 2'b01;
            gap_d   = GW'(GAP);
          end
        end
      end
      S_ISSUE: begin
        state_d = (gap_q != '0) ? S_GAP : S_IDLE;
      end
      S_GAP: begin
        if (gap_q == '0) begin
          state_d = S_IDLE;
        end else if (CE_CPU) begin
          gap_d = gap_q - GW'(1);
          if (gap_q == GW'(1)) begin
            state_d = S_IDLE;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RESET_N) begin
      state_q  <= S_IDLE;
      gap_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      sel_q    <= 1'b0;
      stat_q   <= 1'b0;
      fm_q     <= 1'b1;
      ovf_q    <= 1'b0;
      ym_a0_q  <= 1'b0;
      ym_di_q  <= '0;
      ym_we_q  <= '0;
    end else begin
      state_q  <= state_d;
      gap_q    <= gap_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      sel_q    <= sel_d;
      stat_q   <= stat_d;
      fm_q     <= fm_d;
      ovf_q    <= ovf_d;
      ym_a0_q  <= ym_a0_d;
      ym_di_q  <= ym_di_d;
      ym_we_q  <= ym_we_d;
    end
  end

  // Storage needs no reset: entries are only read while the count is non-zero.
  always_ff @(posedge CLK) begin
    if (RESET_N && push) begin
      mem_q[wr_ptr_q] <= {A0, DI};
    end
  end

  always_comb begin
    if (stat_q) begin
      DO = {fm_q, 6'b000000, busy};
    end else if (sel_q) begin
      DO = DO1;
    end else begin
      DO = DO0;
    end
  end

  assign YM_A0  = ym_a0_q;
  assign YM_DI  = ym_di_q;
  assign YM_WE  = ym_we_q;
  assign FM_ENA = fm_q;
  assign BUSY   = busy;
  assign OVF    = ovf_q;

endmodule

// File: tb/tb_ts_write_sched.sv
// Bench for ts_write_sched: directed scenarios plus random traffic, checked every CLK
// against a tick-indexed queue model of the scheduling rules.
module tb_ts_write_sched;

  localparam int unsigned DEPTH = 8;
  localparam int unsigned GAP   = 3;

  logic       CLK = 1'b0;
  logic       RESET_N = 1'b0;
  logic       CE_CPU = 1'b0;
  logic       WR = 1'b0;
  logic       A0 = 1'b0;
  logic [7:0] DI = '0;
  logic [7:0] DO;
  logic       YM_A0;
  logic [7:0] YM_DI;
  logic [1:0] YM_WE;
  logic [7:0] DO0 = '0;
  logic [7:0] DO1 = '0;
  logic       FM_ENA;
  logic       BUSY;
  logic       OVF;

  ts_write_sched #(.DEPTH(DEPTH), .GAP(GAP)) dut (
    .CLK    (CLK),
    .RESET_N(RESET_N),
    .CE_CPU (CE_CPU),
    .WR     (WR),
    .A0     (A0),
    .DI     (DI),
    .DO     (DO),
    .YM_A0  (YM_A0),
    .YM_DI  (YM_DI),
    .YM_WE  (YM_WE),
    .DO0    (DO0),
    .DO1    (DO1),
    .FM_ENA (FM_ENA),
    .BUSY   (BUSY),
    .OVF    (OVF)
  );

  always #5 CLK = ~CLK;

  int checks = 0;
  int passes = 0;
  int fails  = 0;

  // Model: pending entries, tick index, tick of the last normal issue.
  logic [8:0] q[$];
  int         tick_no = 0;
  int         t_norm = -100;
  int         since_ce = 10;
  int         n_we = 0;
  bit         m_sel = 0, m_stat = 0, m_fm = 1, m_ovf = 0, m_a0 = 0, m_busy = 0;
  logic [7:0] m_di = '0;
  logic [1:0] m_we = '0;
  logic [7:0] m_do;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s: observed %h expected %h at t=%0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_edge(input bit ce, input bit wr, input bit a0, input logic [7:0] di,
                            input bit rst_n);
    logic [8:0] e;
    if (!rst_n) begin
      q.delete();
      tick_no = 0;
      t_norm  = -100;
      m_sel = 0; m_stat = 0; m_fm = 1; m_ovf = 0; m_a0 = 0; m_di = '0; m_we = '0;
    end else begin
      m_we = '0;
      if (ce) begin
        tick_no++;
        if (q.size() > 0 && tick_no >= t_norm + int'(GAP) + 1) begin
          e = q.pop_front();
          if (!e[8] && e[7:3] == 5'b11111) begin
            m_sel  = ~e[0];
            m_stat = ~e[1];
            m_fm   = ~e[2];
          end else begin
            m_a0   = e[8];
            m_di   = e[7:0];
            m_we   = m_sel ? 2'b10 : 2'b01;
            t_norm = tick_no;
          end
        end
      end
      if (wr) begin
        if (q.size() < int'(DEPTH)) q.push_back({a0, di});
        else m_ovf = 1;
      end
    end
    m_busy = (q.size() > 0) || (tick_no < t_norm + int'(GAP));
    m_do   = m_stat ? {m_fm, 6'b000000, m_busy} : (m_sel ? DO1 : DO0);
  endtask

  task automatic step(input bit ce, input bit wr, input bit a0, input logic [7:0] di,
                      input bit rst_n);
    bit ce_eff;
    ce_eff  = ce && (since_ce >= 2);
    CE_CPU  = ce_eff;
    WR      = wr;
    A0      = a0;
    DI      = di;
    RESET_N = rst_n;
    DO0     = 8'($urandom);
    DO1     = 8'($urandom);
    @(posedge CLK);
    model_edge(ce_eff, wr, a0, di, rst_n);
    since_ce = ce_eff ? 1 : since_ce + 1;
    #1;
    if (YM_WE != 2'b00) n_we++;
    chk("ym_we",  {6'b0, YM_WE}, {6'b0, m_we});
    chk("ym_a0",  {7'b0, YM_A0}, {7'b0, m_a0});
    chk("ym_di",  YM_DI, m_di);
    chk("fm_ena", {7'b0, FM_ENA}, {7'b0, m_fm});
    chk("busy",   {7'b0, BUSY}, {7'b0, m_busy});
    chk("ovf",    {7'b0, OVF}, {7'b0, m_ovf});
    chk("do",     DO, m_do);
  endtask

  task automatic run(input int n, input int per);
    for (int i = 0; i < n; i++) step(i % per == 0, 0, 0, 8'h00, 1);
  endtask

  task automatic wr1(input bit a0, input logic [7:0] di);
    step(0, 1, a0, di, 1);
  endtask

  task automatic do_reset(input int n);
    for (int i = 0; i < n; i++) step(0, 1, 1, 8'hA5, 0);
  endtask

  initial begin
    int we_before;
    logic [7:0] d;

    // Reset with write strobes present
    do_reset(3);
    run(4, 4);

    // Single writes: 0/07h then 1/3Eh, CE every 4 CLK
    wr1(0, 8'h07);
    wr1(1, 8'h3E);
    run(40, 4);

    // Chip switch: FEh selects chip 1 and is never forwarded
    we_before = n_we;
    wr1(0, 8'hFE);
    wr1(0, 8'h08);
    run(40, 4);
    chk("switch_we_count", 8'(n_we - we_before), 8'd1);

    // Status readback with FM disabled
    wr1(0, 8'hFD);
    run(12, 4);

    // Overflow: ten writes with no ticks
    do_reset(2);
    for (int i = 0; i < 10; i++) wr1(1, 8'(8'h10 + i));
    we_before = n_we;
    run(150, 3);
    chk("ovf_issue_count", 8'(n_we - we_before), 8'd8);

    // Full FIFO with a write on the issue CLK
    do_reset(2);
    for (int i = 0; i < 8; i++) wr1(0, 8'(8'h20 + i));
    step(1, 1, 1, 8'h77, 1);
    run(150, 3);

    // Reset while in the gap with entries still queued
    do_reset(2);
    for (int i = 0; i < 4; i++) wr1(1, 8'(8'h40 + i));
    run(6, 4);
    do_reset(2);
    we_before = n_we;
    run(30, 3);
    chk("midgap_no_we", 8'(n_we - we_before), 8'd0);

    // Random traffic
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 3) == 0) d = 8'hF8 | 8'($urandom_range(0, 7));
      else d = 8'($urandom);
      step($urandom_range(0, 2) == 0, $urandom_range(0, 1) == 1,
           (d[7:3] == 5'b11111) ? 1'b0 : 1'($urandom), d,
           $urandom_range(0, 399) != 0);
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
